// File: rtl/stack_ram_pkg.sv
// stack_ram_pkg
// Shared definitions for the stack RAM controller: FSM state encodings and
// the default data/address widths matching the 32x8 RAM instance.
package stack_ram_pkg;

  localparam int DEF_N = 8;  // data width, must match the RAM's n
  localparam int DEF_A = 5;  // address width, stack depth is 2**A

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    CAPT  = 2'd3
  } state_t;

endpackage

// File: rtl/stack_ram_ctrl.sv
// stack_ram_ctrl
// Turns push/pop requests into WE/Address/D cycles on a sibling single-port
// RAM so the datapath can use it as a LIFO operand stack.
//
// Ports:
//   i_clk, i_clear_n         clock, asynchronous active-low reset
//   i_push, i_pop, i_din     request interface, sampled only while o_ready=1
//   o_ready                  idle and accepting a request
//   o_dout, o_dout_valid     last popped value, one-cycle update pulse
//   o_full, o_empty, o_count occupancy status (o_count equals the stack pointer)
//   o_error                  one-cycle pulse when a request is rejected
//   o_ram_we/o_ram_addr/o_ram_d  drive the RAM WE/Address/D
//   i_ram_q                  RAM Q (combinational or one-cycle registered)
module stack_ram_ctrl
  import stack_ram_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int A = DEF_A
) (
  input  logic         i_clk,
  input  logic         i_clear_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [N-1:0] i_din,
  output logic         o_ready,
  output logic [N-1:0] o_dout,
  output logic         o_dout_valid,
  output logic         o_full,
  output logic         o_empty,
  output logic [A:0]   o_count,
  output logic         o_error,
  output logic         o_ram_we,
  output logic [A-1:0] o_ram_addr,
  output logic [N-1:0] o_ram_d,
  input  logic [N-1:0] i_ram_q
);

  localparam logic [A:0]   L_DEPTH    = {1'b1, {A{1'b0}}};
  localparam logic [A:0]   L_SP_ONE   = {{A{1'b0}}, 1'b1};
  localparam logic [A-1:0] L_ADDR_ONE = {{(A-1){1'b0}}, 1'b1};

  state_t         r_state, w_state_next;
  logic [A:0]     r_sp, w_sp_next;
  logic           r_ram_we, w_ram_we_next;
  logic [A-1:0]   r_ram_addr, w_ram_addr_next;
  logic [N-1:0]   r_ram_d, w_ram_d_next;
  logic [N-1:0]   r_dout, w_dout_next;
  logic           r_dout_valid, w_dout_valid_next;
  logic           r_error, w_error_next;
  logic           r_ready, r_full, r_empty;

  // State and all registered outputs. Async reset also drops r_ram_we at
  // once, so an interrupted WRITE never completes in the RAM.
  always_ff @(posedge i_clk or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_state      <= IDLE;
      r_sp         <= '0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_d      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_error      <= 1'b0;
      r_ready      <= 1'b1;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_sp         <= w_sp_next;
      r_ram_we     <= w_ram_we_next;
      r_ram_addr   <= w_ram_addr_next;
      r_ram_d      <= w_ram_d_next;
      r_dout       <= w_dout_next;
      r_dout_valid <= w_dout_valid_next;
      r_error      <= w_error_next;
      // Status flags are derived from next-state values so they stay registered
      // yet change on the same edge as the state/pointer they describe.
      r_ready      <= (w_state_next == IDLE);
      r_full       <= (w_sp_next == L_DEPTH);
      r_empty      <= (w_sp_next == '0);
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_sp_next         = r_sp;
    w_ram_we_next     = 1'b0;
    w_ram_addr_next   = r_ram_addr;
    w_ram_d_next      = r_ram_d;
    w_dout_next       = r_dout;
    w_dout_valid_next = 1'b0;
    w_error_next      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_push && !i_pop && !r_full) begin
          // Next free slot is sp; the pointer advances only once WRITE ends.
          w_state_next    = WRITE;
          w_ram_we_next   = 1'b1;
          w_ram_addr_next = r_sp[A-1:0];
          w_ram_d_next    = i_din;
        end else if (i_pop && !i_push && !r_empty) begin
          // Top of stack is sp-1; occupancy drops immediately on acceptance.
          w_state_next    = READ;
          w_sp_next       = r_sp - L_SP_ONE;
          w_ram_addr_next = r_sp[A-1:0] - L_ADDR_ONE;
        end else if (i_push || i_pop) begin
          // Overflow, underflow or simultaneous push+pop: no operation.
          w_error_next = 1'b1;
        end
      end
      WRITE: begin
        w_state_next = IDLE;
        w_sp_next    = r_sp + L_SP_ONE;
      end
      READ: begin
        // Address held a second cycle so registered-Q RAMs also settle.
        w_state_next = CAPT;
      end
      CAPT: begin
        w_state_next      = IDLE;
        w_dout_next       = i_ram_q;
        w_dout_valid_next = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_ready      = r_ready;
  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_full       = r_full;
  assign o_empty      = r_empty;
  assign o_count      = r_sp;
  assign o_error      = r_error;
  assign o_ram_we     = r_ram_we;
  assign o_ram_addr   = r_ram_addr;
  assign o_ram_d      = r_ram_d;

endmodule
